// File: rtl/seq_logic_pkg.sv
// rtl/seq_logic_pkg.sv - shared constants for the seq_logic storage library
//
// Holds the library-wide default reset value. Every storage primitive takes its
// RESET_VAL default from here. This keeps the cells consistent when a caller does
// not override the value.
package seq_logic_pkg;

    localparam logic SEQ_RESET_DEFAULT = 1'b0;

endpackage : seq_logic_pkg

// File: rtl/d_latch_bit.sv
// rtl/d_latch_bit.sv - single-bit transparent-high D latch cell with async active-low clear
//
// Ports:
//   clk   in  1  latch enable: transparent when 1, opaque when 0
//   rst_n in  1  asynchronous active-low clear, forces q to RESET_VAL
//   d     in  1  data input
//   q     out 1  latched data output
//
// The default build is the behavioural form. Defining GATE_LEVEL selects a gated
// NAND SR latch that has the same port behaviour. In that form, reset is folded
// into the set/reset requests. This means the cross-coupled pair is always driven
// to RESET_VAL while rst_n is low.
module d_latch_bit
    import seq_logic_pkg::*;
#(
    parameter logic RESET_VAL = SEQ_RESET_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

`ifndef GATE_LEVEL

    // Reset has priority over the enable. While clk is high, q tracks d with no
    // latency. While clk is low, q keeps the last value that d had before clk fell.
    always_latch begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else if (clk) begin
            q <= d;
        end
    end

`else

    logic set_req;
    logic clr_req;
    logic set_n;
    logic clr_n;
    logic q_int;
    logic qb_int;

    // While reset is active, the requests are steered to RESET_VAL. Otherwise the
    // requests come from the usual gated-D input stage.
    assign set_req = rst_n ? (clk &  d) :  RESET_VAL;
    assign clr_req = rst_n ? (clk & ~d) : ~RESET_VAL;

    assign set_n  = ~set_req;
    assign clr_n  = ~clr_req;

    // Cross-coupled NAND pair. Both requests inactive means the pair holds its state.
    assign q_int  = ~(set_n & qb_int);
    assign qb_int = ~(clr_n & q_int);

    assign q = q_int;

`endif

endmodule : d_latch_bit

// File: rtl/d_latch.sv
// rtl/d_latch.sv - WIDTH-bit transparent-high D latch with async active-low clear
//
// Ports:
//   clk   in  1      latch enable: transparent when 1, opaque when 0
//   rst_n in  1      asynchronous active-low clear, forces q to RESET_VAL
//   d     in  WIDTH  data input
//   q     out WIDTH  latched data output
//
// Each bit is an independent d_latch_bit cell. Bit i of RESET_VAL sets the clear
// value of cell i.
module d_latch
    import seq_logic_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{SEQ_RESET_DEFAULT}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            d_latch_bit #(
                .RESET_VAL (RESET_VAL[gi])
            ) u_bit (
                .clk   (clk),
                .rst_n (rst_n),
                .d     (d[gi]),
                .q     (q[gi])
            );
        end
    endgenerate

endmodule : d_latch

// File: tb/tb_d_latch.sv
// tb/tb_d_latch.sv - directed self-checking bench for d_latch
module tb_d_latch;

    logic       clk;
    logic       rst_n;
    logic       d1;
    logic [0:0] q1;
    logic [7:0] d8;
    logic [7:0] q8;

    int tests_run    = 0;
    int tests_failed = 0;

    d_latch #(
        .WIDTH     (1),
        .RESET_VAL (1'b0)
    ) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (d1),
        .q     (q1)
    );

    d_latch #(
        .WIDTH     (8),
        .RESET_VAL (8'hA5)
    ) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (d8),
        .q     (q8)
    );

    task automatic test_reset();
        rst_n = 1'b0; clk = 1'b0; d1 = 1'b1;
        #10;
        tests_run++;
        if (q1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_asserted: q=%b expected 0", q1);
        end
        rst_n = 1'b1;
        #10;
        tests_run++;
        if (q1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release_clk_low: q=%b expected 0", q1);
        end
    endtask

    task automatic test_transparent();
        clk = 1'b1; d1 = 1'b0;
        #10;
        tests_run++;
        if (q1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL transparent_d0: q=%b expected 0", q1);
        end
        d1 = 1'b1;
        #1;
        tests_run++;
        if (q1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL transparent_d1_immediate: q=%b expected 1", q1);
        end
        #9;
        tests_run++;
        if (q1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL transparent_d1: q=%b expected 1", q1);
        end
    endtask

    task automatic test_hold();
        clk = 1'b1; d1 = 1'b0;
        #10;
        clk = 1'b0;
        #10;
        d1 = 1'b1;
        #10;
        tests_run++;
        if (q1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_ignores_d: q=%b expected 0", q1);
        end
        clk = 1'b1;
        #10;
        tests_run++;
        if (q1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL hold_reopen: q=%b expected 1", q1);
        end
    endtask

    task automatic test_capture_on_fall();
        clk = 1'b1; d1 = 1'b1;
        #10;
        clk = 1'b0;
        #10;
        d1 = 1'b0;
        #10;
        tests_run++;
        if (q1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL capture_fall: q=%b expected 1", q1);
        end
        for (int i = 0; i < 6; i++) begin
            d1 = ~d1;
            #10;
            tests_run++;
            if (q1 !== 1'b1) begin
                tests_failed++;
                $display("FAIL capture_toggle_%0d: q=%b expected 1", i, q1);
            end
        end
    endtask

    // d and clk change in the same timestep. The new d only counts if clk is
    // still high after the update.
    task automatic test_same_timestep();
        clk = 1'b1; d1 = 1'b1;
        #10;
        d1 = 1'b0; clk = 1'b0;
        #10;
        tests_run++;
        if (q1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL same_step_fall: q=%b expected 1", q1);
        end
        d1 = 1'b0; clk = 1'b1;
        #10;
        tests_run++;
        if (q1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL same_step_rise: q=%b expected 0", q1);
        end
        clk = 1'b0;
        #10;
    endtask

    task automatic test_async_reset_transparent();
        clk = 1'b1; d1 = 1'b1;
        #10;
        tests_run++;
        if (q1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL async_pre: q=%b expected 1", q1);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (q1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset_immediate: q=%b expected 0", q1);
        end
        #9;
        tests_run++;
        if (q1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset_held: q=%b expected 0", q1);
        end
        rst_n = 1'b1;
        #10;
        tests_run++;
        if (q1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL release_clk_high: q=%b expected 1", q1);
        end
        clk = 1'b0;
        #10;
    endtask

    task automatic test_width8();
        clk = 1'b0; d8 = 8'h00; rst_n = 1'b0;
        #10;
        tests_run++;
        if (q8 !== 8'hA5) begin
            tests_failed++;
            $display("FAIL w8_reset: q=%h expected a5", q8);
        end
        rst_n = 1'b1;
        #10;
        tests_run++;
        if (q8 !== 8'hA5) begin
            tests_failed++;
            $display("FAIL w8_release_clk_low: q=%h expected a5", q8);
        end
        clk = 1'b1; d8 = 8'h3C;
        #10;
        tests_run++;
        if (q8 !== 8'h3C) begin
            tests_failed++;
            $display("FAIL w8_transparent: q=%h expected 3c", q8);
        end
        clk = 1'b0;
        #10;
        d8 = 8'hFF;
        #10;
        tests_run++;
        if (q8 !== 8'h3C) begin
            tests_failed++;
            $display("FAIL w8_hold: q=%h expected 3c", q8);
        end
        clk = 1'b1;
        #10;
        tests_run++;
        if (q8 !== 8'hFF) begin
            tests_failed++;
            $display("FAIL w8_reopen: q=%h expected ff", q8);
        end
        rst_n = 1'b0;
        #10;
        tests_run++;
        if (q8 !== 8'hA5) begin
            tests_failed++;
            $display("FAIL w8_reset_transparent: q=%h expected a5", q8);
        end
        rst_n = 1'b1; clk = 1'b0;
        #10;
    endtask

    initial begin
        rst_n = 1'b0;
        clk   = 1'b0;
        d1    = 1'b0;
        d8    = 8'h00;
        test_reset();
        test_transparent();
        test_hold();
        test_capture_on_fall();
        test_same_timestep();
        test_async_reset_transparent();
        test_width8();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_d_latch
